// File: rtl/moore_pkg.sv
// Shared types and helpers for the Moore pattern transmitter path.
package moore_pkg;

  // Transmitter FSM encoding.
  typedef enum logic [1:0] {
    TxIdle = 2'd0,
    TxSend = 2'd1,
    TxGap  = 2'd2
  } tx_state_t;

  // Default level driven on the serial line when no frame is in flight.
  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Saturate a requested length: 0 or anything above width means a full word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned width);
    return ((len == 0) || (len > width)) ? width : len;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, shift-left register; zeros shift in at the LSB.
module piso_shreg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] q_o,
  output logic             msb_o
);

  logic [Width-1:0] sreg_q, sreg_d;

  // Load has priority over shift.
  always_comb begin
    sreg_d = sreg_q;
    if (load_i) begin
      sreg_d = data_i;
    end else if (shift_i) begin
      sreg_d = {sreg_q[Width-2:0], 1'b0};
    end
  end

  // Register state with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

  assign q_o   = sreg_q;
  assign msb_o = sreg_q[Width-1];

endmodule

// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: takes a word over valid/ready and sends it MSB-first,
// one bit per clock, followed by an optional idle gap.
module moore_pattern_tx
  import moore_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LEN_W      = $clog2(WIDTH + 1),
  parameter int unsigned GAP        = 1,
  parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [WIDTH-1:0] pat_data,
  input  logic [LEN_W-1:0] pat_len,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  tx_state_t        state_q, state_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sreg_load, sreg_shift;
  logic [WIDTH-1:0] sreg_q;
  logic             sreg_msb;
  logic [WIDTH-1:0] load_val;
  int unsigned      len_eff;
  logic             gap_load;
  logic             gap_last;

  // Align the pattern so its first bit lands at the register MSB.
  assign len_eff  = eff_len(32'(pat_len), WIDTH);
  assign load_val = pat_data << (WIDTH - len_eff);

  piso_shreg #(
    .Width (WIDTH)
  ) u_shreg (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (sreg_load),
    .shift_i (sreg_shift),
    .data_i  (load_val),
    .q_o     (sreg_q),
    .msb_o   (sreg_msb)
  );

  // Ready comes from the state register alone, never from pat_valid.
  assign pat_ready = (state_q == TxIdle);

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = IDLE_LEVEL;
    dout_valid_d = 1'b0;
    done_d       = 1'b0;
    sreg_load    = 1'b0;
    sreg_shift   = 1'b0;
    gap_load     = 1'b0;
    unique case (state_q)
      TxIdle: begin
        if (pat_valid) begin
          // First bit goes out on the handshake edge itself.
          sreg_load    = 1'b1;
          bit_cnt_d    = LEN_W'(len_eff);
          dout_d       = load_val[WIDTH-1];
          dout_valid_d = 1'b1;
          state_d      = TxSend;
        end
      end
      TxSend: begin
        sreg_shift = 1'b1;
        if (bit_cnt_q == LEN_W'(1)) begin
          bit_cnt_d = '0;
          done_d    = 1'b1;
          gap_load  = 1'b1;
          state_d   = (GAP > 0) ? TxGap : TxIdle;
        end else begin
          // sreg_q[WIDTH-1] is on the line now; the next bit sits just below it.
          bit_cnt_d    = bit_cnt_q - LEN_W'(1);
          dout_d       = sreg_q[WIDTH-2];
          dout_valid_d = 1'b1;
        end
      end
      TxGap: begin
        if (gap_last) begin
          state_d = TxIdle;
        end
      end
      default: state_d = TxIdle;
    endcase
    busy_d = (state_d != TxIdle);
  end

  // Gap counter only exists when a gap is configured.
  if (GAP > 0) begin : g_gap
    localparam int unsigned GapW = $clog2(GAP + 1);
    logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

    // Load on leaving SEND, count down while in GAP.
    always_comb begin
      gap_cnt_d = gap_cnt_q;
      if (gap_load) begin
        gap_cnt_d = GapW'(GAP);
      end else if ((state_q == TxGap) && (gap_cnt_q != '0)) begin
        gap_cnt_d = gap_cnt_q - GapW'(1);
      end
    end

    // Gap counter register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        gap_cnt_q <= '0;
      end else begin
        gap_cnt_q <= gap_cnt_d;
      end
    end

    assign gap_last = (gap_cnt_q == GapW'(1));
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end

  // State, counter and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= TxIdle;
      bit_cnt_q    <= '0;
      dout_q       <= IDLE_LEVEL;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

  // MSB is exposed for observers; the FSM looks one bit ahead instead.
  logic unused_msb;
  assign unused_msb = sreg_msb;

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Directed bench for moore_pattern_tx: one GAP=1 instance and one GAP=0 instance.
module tb_moore_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic       pat_valid = 1'b0;
  logic       pat_ready;
  logic [7:0] pat_data = '0;
  logic [3:0] pat_len = '0;
  logic       dout, dout_valid, busy, done;

  logic       v0 = 1'b0;
  logic       r0;
  logic [7:0] d0 = '0;
  logic [3:0] l0 = '0;
  logic       o0, ov0, b0, dn0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  moore_pattern_tx #(
    .WIDTH (8),
    .GAP   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pat_valid  (pat_valid),
    .pat_ready  (pat_ready),
    .pat_data   (pat_data),
    .pat_len    (pat_len),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  moore_pattern_tx #(
    .WIDTH (8),
    .GAP   (0)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .pat_valid  (v0),
    .pat_ready  (r0),
    .pat_data   (d0),
    .pat_len    (l0),
    .dout       (o0),
    .dout_valid (ov0),
    .busy       (b0),
    .done       (dn0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on the GAP=1 instance; mut_at >= 0 scrambles inputs at that bit.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [3:0] l,
                           input logic [7:0] exp, input int n, input int mut_at);
    pat_valid = 1'b1;
    pat_data  = d;
    pat_len   = l;
    tick();
    pat_valid = 1'b0;
    chk({tag, " ready_low"}, pat_ready, 1'b0);
    chk({tag, " busy"}, busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      if (i == mut_at) begin
        pat_data = 8'h00;
        pat_len  = 4'd3;
      end
      chk($sformatf("%s bit%0d", tag, i), dout, exp[n-1-i]);
      chk($sformatf("%s valid%0d", tag, i), dout_valid, 1'b1);
      tick();
    end
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " valid_end"}, dout_valid, 1'b0);
    chk({tag, " dout_idle"}, dout, 1'b0);
    chk({tag, " busy_gap"}, busy, 1'b1);
    chk({tag, " ready_gap"}, pat_ready, 1'b0);
    tick();
    chk({tag, " done_once"}, done, 1'b0);
    chk({tag, " ready_back"}, pat_ready, 1'b1);
    chk({tag, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] f0;
    logic [7:0] f1;
    f0 = 8'hF0;
    f1 = 8'h0F;

    // Reset state.
    #12;
    chk("rst dout", dout, 1'b0);
    chk("rst valid", dout_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst ready", pat_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("idle ready", pat_ready, 1'b1);

    // Basic frames and length handling.
    run_frame("f75", 8'b0111_0101, 4'd8, 8'b0111_0101, 8, -1);
    run_frame("ab4", 8'hAB, 4'd4, 8'b0000_1011, 4, -1);
    run_frame("ab0", 8'hAB, 4'd0, 8'hAB, 8, -1);
    run_frame("ab15", 8'hAB, 4'd15, 8'hAB, 8, -1);
    run_frame("c3mut", 8'hC3, 4'd8, 8'b1100_0011, 8, 3);

    // pat_valid held high: F0 then 0F, each handshake only from IDLE.
    pat_valid = 1'b1;
    pat_data  = 8'hF0;
    pat_len   = 4'd8;
    tick();
    pat_data = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bb0 bit%0d", i), dout, f0[7-i]);
      chk($sformatf("bb0 valid%0d", i), dout_valid, 1'b1);
      tick();
    end
    chk("bb gap valid", dout_valid, 1'b0);
    chk("bb gap ready", pat_ready, 1'b0);
    chk("bb gap done", done, 1'b1);
    tick();
    chk("bb idle valid", dout_valid, 1'b0);
    chk("bb idle ready", pat_ready, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("bb1 bit%0d", i), dout, f1[7-i]);
      chk($sformatf("bb1 valid%0d", i), dout_valid, 1'b1);
      if (i == 7) pat_valid = 1'b0;
      tick();
    end
    chk("bb1 done", done, 1'b1);
    tick();
    tick();
    chk("bb1 no_restart", dout_valid, 1'b0);
    chk("bb1 ready", pat_ready, 1'b1);

    // GAP=0 instance, back-to-back 8'h81.
    v0 = 1'b1;
    d0 = 8'h81;
    l0 = 4'd8;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("g0a bit%0d", i), o0, (i == 0 || i == 7) ? 1'b1 : 1'b0);
      chk($sformatf("g0a valid%0d", i), ov0, 1'b1);
      chk($sformatf("g0a ready%0d", i), r0, 1'b0);
      tick();
    end
    chk("g0 done", dn0, 1'b1);
    chk("g0 ready", r0, 1'b1);
    chk("g0 valid", ov0, 1'b0);
    chk("g0 busy", b0, 1'b0);
    tick();
    v0 = 1'b0;
    chk("g0b first", o0, 1'b1);
    chk("g0b valid", ov0, 1'b1);
    chk("g0b done_once", dn0, 1'b0);
    for (int i = 0; i < 7; i++) tick();
    chk("g0b last", o0, 1'b1);
    tick();
    chk("g0b done", dn0, 1'b1);
    tick();
    chk("g0 idle valid", ov0, 1'b0);

    // Reset during the 3rd bit of 8'hFF.
    pat_valid = 1'b1;
    pat_data  = 8'hFF;
    pat_len   = 4'd8;
    tick();
    pat_valid = 1'b0;
    tick();
    tick();
    chk("ff bit3", dout, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst dout", dout, 1'b0);
    chk("arst valid", dout_valid, 1'b0);
    chk("arst busy", busy, 1'b0);
    chk("arst done", done, 1'b0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post rst done", done, 1'b0);
    chk("post rst ready", pat_ready, 1'b1);
    run_frame("f55", 8'h55, 4'd8, 8'h55, 8, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
